// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MIPS WB stage: MEM/WB register, load wait, register-file write and ID forwarding
module writeback_stage #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_reg_write,
  input  logic                 in_mem_to_reg,
  input  logic [4:0]           in_dest,
  input  logic [31:0]          in_alu_result,
  input  logic                 mem_rdata_valid,
  input  logic [31:0]          mem_rdata,
  input  logic                 flush,
  output logic                 wb_reg_write,
  output logic [4:0]           wb_write_reg,
  output logic [31:0]          wb_write_data,
  output logic                 fwd_valid,
  output logic                 fwd_pending,
  output logic [4:0]           fwd_reg,
  output logic [31:0]          fwd_data,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_READY    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [4:0]            dest_q, dest_d;
  logic [31:0]           data_q, data_d;
  logic [CNT_WIDTH-1:0]  retired_count_q, retired_count_d;

  logic accept;
  logic held;

  assign in_ready = !rst && !flush && (state_q != ST_WAIT_MEM);
  assign accept   = in_valid && in_ready;
  assign held     = (state_q != ST_EMPTY);

  always_comb begin
    state_d         = state_q;
    reg_write_d     = reg_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    dest_d          = dest_q;
    data_d          = data_q;
    retired_count_d = retired_count_q;

    // Anything sitting in READY is committed and retires on this edge, flush or not.
    if (state_q == ST_READY) begin
      retired_count_d = retired_count_q + CNT_WIDTH'(1);
    end

    case (state_q)
      ST_EMPTY, ST_READY: begin
        if (accept) begin
          reg_write_d  = in_reg_write;
          mem_to_reg_d = in_mem_to_reg;
          dest_d       = in_dest;
          data_d       = in_alu_result;
          if (in_reg_write && in_mem_to_reg) begin
            state_d = ST_WAIT_MEM;
          end else begin
            state_d = ST_READY;
          end
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_WAIT_MEM: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (mem_rdata_valid) begin
          data_d  = mem_rdata;
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_EMPTY;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      dest_q          <= 5'd0;
      data_q          <= 32'd0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      reg_write_q     <= reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      dest_q          <= dest_d;
      data_q          <= data_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Writes to $0 are dropped here so ID never forwards a non-zero value for $0.
  assign wb_reg_write  = (state_q == ST_READY) && reg_write_q && (dest_q != 5'd0);
  assign wb_write_reg  = held ? dest_q : 5'd0;
  assign wb_write_data = held ? data_q : 32'd0;

  assign fwd_valid     = wb_reg_write;
  assign fwd_pending   = (state_q == ST_WAIT_MEM) && (dest_q != 5'd0);
  assign fwd_reg       = held ? dest_q : 5'd0;
  assign fwd_data      = wb_write_data;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [4:0]  in_dest;
  logic [31:0] in_alu_result;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        fwd_valid;
  logic        fwd_pending;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [31:0] retired_count;

  int n_compared;
  int n_mismatched;

  writeback_stage #(.CNT_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_reg_write   (in_reg_write),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_dest        (in_dest),
    .in_alu_result  (in_alu_result),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata      (mem_rdata),
    .flush          (flush),
    .wb_reg_write   (wb_reg_write),
    .wb_write_reg   (wb_write_reg),
    .wb_write_data  (wb_write_data),
    .fwd_valid      (fwd_valid),
    .fwd_pending    (fwd_pending),
    .fwd_reg        (fwd_reg),
    .fwd_data       (fwd_data),
    .retired_count  (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input logic rw, input logic m2r, input logic [4:0] d, input logic [31:0] alu);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_dest       = d;
    in_alu_result = alu;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'd0);
    check_eq({tag, "_wb_write_reg"}, 32'(wb_write_reg), 32'd0);
    check_eq({tag, "_wb_write_data"}, wb_write_data, 32'd0);
    check_eq({tag, "_fwd_pending"}, 32'(fwd_pending), 32'd0);
    check_eq({tag, "_fwd_reg"}, 32'(fwd_reg), 32'd0);
    check_eq({tag, "_retired"}, retired_count, 32'd0);
  endtask

  initial begin
    n_compared      = 0;
    n_mismatched    = 0;
    rst             = 1'b1;
    in_valid        = 1'b0;
    in_reg_write    = 1'b0;
    in_mem_to_reg   = 1'b0;
    in_dest         = 5'd0;
    in_alu_result   = 32'd0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = 32'd0;
    flush           = 1'b0;

    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    #1 check_eq("ready_after_reset", 32'(in_ready), 32'd1);

    // Reset asserted while a load is waiting
    offer(1'b1, 1'b1, 5'd7, 32'h55);
    tick();
    in_valid = 1'b0;
    check_eq("wait_in_ready", 32'(in_ready), 32'd0);
    check_eq("wait_pending", 32'(fwd_pending), 32'd1);
    check_eq("wait_fwd_reg", 32'(fwd_reg), 32'd7);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    #1 check_eq("rel_in_ready", 32'(in_ready), 32'd1);
    check_eq("rel_retired", retired_count, 32'd0);
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'hBAD;
    tick();
    mem_rdata_valid = 1'b0;
    check_eq("stale_rdata_write", 32'(wb_reg_write), 32'd0);
    check_eq("stale_rdata_reg", 32'(fwd_reg), 32'd0);
    check_eq("stale_rdata_retired", retired_count, 32'd0);

    // Single ALU op
    offer(1'b1, 1'b0, 5'd5, 32'h2A);
    tick();
    in_valid = 1'b0;
    check_eq("alu_we", 32'(wb_reg_write), 32'd1);
    check_eq("alu_reg", 32'(wb_write_reg), 32'd5);
    check_eq("alu_data", wb_write_data, 32'h2A);
    check_eq("alu_fwd_valid", 32'(fwd_valid), 32'd1);
    check_eq("alu_fwd_data", fwd_data, 32'h2A);
    check_eq("alu_retired_before", retired_count, 32'd0);
    tick();
    check_eq("alu_idle_we", 32'(wb_reg_write), 32'd0);
    check_eq("alu_idle_data", wb_write_data, 32'd0);
    check_eq("alu_idle_fwd_reg", 32'(fwd_reg), 32'd0);
    check_eq("alu_retired", retired_count, 32'd1);

    // Load with data three cycles later
    offer(1'b1, 1'b1, 5'd8, 32'h0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("ld_in_ready", 32'(in_ready), 32'd0);
      check_eq("ld_pending", 32'(fwd_pending), 32'd1);
      check_eq("ld_fwd_reg", 32'(fwd_reg), 32'd8);
      check_eq("ld_we_wait", 32'(wb_reg_write), 32'd0);
      if (i == 2) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hDEADBEEF;
      end
      tick();
    end
    mem_rdata_valid = 1'b0;
    check_eq("ld_we", 32'(wb_reg_write), 32'd1);
    check_eq("ld_reg", 32'(wb_write_reg), 32'd8);
    check_eq("ld_data", wb_write_data, 32'hDEADBEEF);
    check_eq("ld_pending_done", 32'(fwd_pending), 32'd0);
    tick();
    check_eq("ld_we_after", 32'(wb_reg_write), 32'd0);
    check_eq("ld_retired", retired_count, 32'd2);

    // Four back-to-back ALU ops
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, 1'b0, 5'(i), 32'h11 * i);
      check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
      check_eq("b2b_we", 32'(wb_reg_write), 32'd1);
      check_eq("b2b_reg", 32'(wb_write_reg), i);
      check_eq("b2b_data", wb_write_data, 32'h11 * i);
    end
    in_valid = 1'b0;
    tick();
    check_eq("b2b_retired", retired_count, 32'd6);

    // Write to $0, then a store with mem_to_reg set
    offer(1'b1, 1'b0, 5'd0, 32'h77);
    tick();
    check_eq("r0_we", 32'(wb_reg_write), 32'd0);
    check_eq("r0_fwd_valid", 32'(fwd_valid), 32'd0);
    offer(1'b0, 1'b1, 5'd3, 32'h99);
    check_eq("st_in_ready_pre", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("st_we", 32'(wb_reg_write), 32'd0);
    check_eq("st_in_ready", 32'(in_ready), 32'd1);
    check_eq("st_pending", 32'(fwd_pending), 32'd0);
    tick();
    check_eq("st_retired", retired_count, 32'd8);

    // Flush beats mem_rdata_valid on a waiting load
    offer(1'b1, 1'b1, 5'd9, 32'h0);
    tick();
    in_valid = 1'b0;
    check_eq("fl_pending", 32'(fwd_pending), 32'd1);
    flush           = 1'b1;
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'h1234;
    #1 check_eq("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush           = 1'b0;
    mem_rdata_valid = 1'b0;
    check_eq("fl_we", 32'(wb_reg_write), 32'd0);
    check_eq("fl_pending_clr", 32'(fwd_pending), 32'd0);
    check_eq("fl_fwd_reg", 32'(fwd_reg), 32'd0);
    tick();
    check_eq("fl_we_later", 32'(wb_reg_write), 32'd0);
    check_eq("fl_retired", retired_count, 32'd8);

    // Flush while READY: the held write completes, the offer is refused
    offer(1'b1, 1'b0, 5'd10, 32'hA5);
    tick();
    offer(1'b1, 1'b0, 5'd11, 32'hB6);
    flush = 1'b1;
    #1 check_eq("flr_in_ready", 32'(in_ready), 32'd0);
    check_eq("flr_we", 32'(wb_reg_write), 32'd1);
    check_eq("flr_reg", 32'(wb_write_reg), 32'd10);
    check_eq("flr_data", wb_write_data, 32'hA5);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flr_we_after", 32'(wb_reg_write), 32'd0);
    check_eq("flr_fwd_reg", 32'(fwd_reg), 32'd0);
    check_eq("flr_retired", retired_count, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MIPS WB pipeline stage: the write-side counterpart of the ID stage.
- Holds the MEM/WB pipeline register and waits for load data when needed.
- Selects the ALU result or the memory word, then drives the register-file write port (the file samples on the rising clk edge).
- Also publishes forward/pending information back to ID for bypass and load-use stall.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
in_valid  input  1  MEM stage offers an instruction
in_ready  output  1  stage can accept this cycle
in_reg_write  input  1  instruction writes a register
in_mem_to_reg  input  1  result comes from memory (load)
in_dest  input  5  destination register, already resolved by the regDst mux
in_alu_result  input  32  ALU result
mem_rdata_valid  input  1  load data valid this cycle
mem_rdata  input  32  load data
flush  input  1  squash any load still waiting; block acceptance
wb_reg_write  output  1  register-file write enable
wb_write_reg  output  5  register-file write address
wb_write_data  output  32  register-file write data
fwd_valid  output  1  fwd_reg/fwd_data hold a ready result
fwd_pending  output  1  load to fwd_reg still waiting for data
fwd_reg  output  5  register being produced
fwd_data  output  32  value being produced
retired_count  output  CNT_WIDTH  instructions retired since reset

Behaviour:
- States:
  - EMPTY: nothing held.
  - WAIT_MEM: load held, data outstanding.
  - READY: result held; retires at the next rising edge.
- in_ready = !rst && !flush && state != WAIT_MEM (combinational). Accept = in_valid && in_ready.
- Latching on accept: reg_write, dest, mem_to_reg and alu_result are captured.
- Next state on accept, from EMPTY or READY:
  - in_reg_write && in_mem_to_reg -> WAIT_MEM.
  - Otherwise -> READY, with data = in_alu_result.
- No accept: READY -> EMPTY (retire); EMPTY stays EMPTY.
- WAIT_MEM:
  - mem_rdata_valid=1 -> capture mem_rdata as data, go to READY.
  - Otherwise stay in WAIT_MEM.
  - mem_rdata_valid is ignored in every other state, including the accept cycle.
- Flush:
  - WAIT_MEM -> EMPTY, with no write and no retire. Flush wins over a simultaneous mem_rdata_valid.
  - A READY entry is already committed: it still writes and retires on that edge.
  - No new accept happens during a flush cycle.
- Write port (combinational from held state):
  - wb_reg_write = (state==READY) && held reg_write && held dest != 0. Writes to $0 are suppressed.
  - wb_write_reg = held dest; wb_write_data = held data. Both are 0 when state is EMPTY.
- Latency:
  - ALU op accepted at edge N is driven in cycle N..N+1 and written at edge N+1.
  - Load is written at the edge after the one that samples mem_rdata_valid.
  - Throughput is 1 per cycle for back-to-back non-loads.
- Forwarding:
  - fwd_valid = wb_reg_write.
  - fwd_pending = (state==WAIT_MEM) && held dest != 0.
  - fwd_reg = held dest while in READY or WAIT_MEM, else 0.
  - fwd_data = wb_write_data.
- Entries with reg_write=0 (stores, branches) pass through READY with no write and still count as retired. For them mem_to_reg is ignored, so they never wait.
- retired_count: +1 at every rising edge leaving READY (including READY->READY), wraps modulo 2^CNT_WIDTH; not incremented on flush.
- Reset (asynchronous, any state, mid-load included):
  - state EMPTY; all held fields 0; retired_count 0.
  - All outputs 0, including in_ready while rst=1.
  - in_ready goes to 1 in the first cycle after rst deasserts.

Test Plan:
- Reset mid-WAIT_MEM -> outputs all 0 immediately (no clock edge); after release in_ready=1, retired_count=0, and a later mem_rdata_valid is ignored.
- ALU op, dest=5, alu_result=0x0000002A, then idle -> one cycle of wb_reg_write=1, wb_write_reg=5, wb_write_data=0x2A, fwd_valid=1; retired_count=1; back to EMPTY.
- Load, dest=8; mem_rdata_valid 3 cycles later with 0xDEADBEEF -> in_ready=0 and fwd_pending=1, fwd_reg=8 while waiting; then one write of 0xDEADBEEF to reg 8; retired_count +1.
- Four back-to-back ALU ops to regs 1-4 (data 0x11/0x22/0x33/0x44) -> in_ready stays 1, four consecutive write cycles in order, retired_count=4.
- Op with dest=0, then op with reg_write=0 and mem_to_reg=1 -> wb_reg_write stays 0 for both, no WAIT_MEM entered, retired_count=2.
- Load waiting to reg 9; flush asserted together with mem_rdata_valid (0x1234) -> no write, state EMPTY, retired_count unchanged. Flush in a READY cycle -> that write still occurs and in_valid that cycle is not accepted.
